alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, 2, input FIFO entries (power of two, >=2).
REQ-002 Parameter: DIVZ_RES, 4'hF, result returned for divide-by-zero.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  FIFO can accept; equals FIFO not full.
REQ-007 in_opc  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 in_op1, in_op2  input  4 each  operands.
REQ-009 alu_enable  output  1  ALU enable, registered.
REQ-010 alu_op1, alu_op2  output  4 each  operands to ALU, registered.
REQ-011 alu_opc  output  2  opcode to ALU, registered.
REQ-012 alu_res  input  4  ALU result (ALU updates on negedge clk).
REQ-013 alu_carry  input  1  ALU carry/borrow.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_res  output  4; out_carry output 1; out_err output 1 (divide-by-zero).

Function
REQ-017 Instruction {opc,op1,op2} SHALL be pushed into FIFO on posedge when in_valid && in_ready; no bypass of an empty FIFO.
REQ-018 FIFO SHALL use wrap-around read/write pointers plus occupancy count 0..DEPTH; push when full impossible (in_ready=0); push and pop in same cycle SHALL leave count unchanged.
REQ-019 FSM states SHALL be IDLE, ISSUE, HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head into alu_op1/alu_op2/alu_opc and go ISSUE next edge; else stay.
REQ-021 ISSUE (exactly one cycle): alu_enable=1, except alu_enable=0 when alu_opc=11 and alu_op2=0.
REQ-022 At the posedge ending ISSUE, out_res/out_carry SHALL capture alu_res/alu_carry, out_err=0, and go HOLD; for divide-by-zero capture out_res=DIVZ_RES, out_carry=0, out_err=1.
REQ-023 HOLD: out_valid=1, outputs stable until out_valid && out_ready.
REQ-024 On HOLD handshake: if FIFO non-empty, pop and go ISSUE directly (back-to-back); else go IDLE.
REQ-025 Latency: push at edge N into empty FIFO with FSM IDLE -> ISSUE during cycle N+1 -> out_valid from edge N+2.
REQ-026 Sustained throughput with out_ready=1: one result per 2 cycles.
REQ-027 alu_enable SHALL be 0 in every state other than ISSUE; alu_op*/alu_opc hold last values.
REQ-028 Operands and opcode SHALL be passed unmodified; no arithmetic performed in this block.

Reset
REQ-029 rst on posedge: FSM to IDLE, FIFO pointers and count to 0, in-flight and buffered instructions discarded.
REQ-030 Reset values: alu_enable=0, alu_op1=alu_op2=0, alu_opc=00, out_valid=0, out_res=0, out_carry=0, out_err=0; in_ready=1 after reset edge.
REQ-031 rst asserted during ISSUE or HOLD SHALL drop the result with no out_valid pulse; rst takes priority over push/pop in same cycle.

Structure
REQ-032 Shared package SHALL hold opcode constants (ADD=00, SUB=01, MUL=10, DIV=11), state encoding, and instruction width constant (10).
REQ-033 FIFO SHALL be a sub-module named issue_fifo (parameter DEPTH, width 10, push/pop/full/empty/count); FSM and output registers live in alu_issue_ctrl.

Verification
REQ-034 Bench SHALL connect the real ALU on negedge clk. Push add op1=9 op2=8 -> out_valid at edge N+2, out_res=1, out_carry=1, out_err=0.
REQ-035 Push div op1=7 op2=0 -> alu_enable never asserted, out_res=4'hF, out_carry=0, out_err=1.
REQ-036 Push 3 instructions back-to-back (sub 3-5, mul 3*6, div 15/4) with out_ready=0 -> in_ready low after second queued entry; release out_ready -> results 4'hE/carry 1, 4'h2/0, 4'h3/0 in order, one per 2 cycles.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> out_res/out_carry/out_err unchanged, alu_enable=0 throughout.
REQ-038 Assert rst for one cycle during ISSUE with FIFO holding 1 entry -> no out_valid, count=0, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared opcodes, FSM encoding and instruction layout for the ALU issue controller
package alu_issue_ctrl_pkg;

  localparam int INSTR_W = 10;

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_MUL = 2'b10;
  localparam logic [1:0] OPC_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] opc;
    logic [3:0] op1;
    logic [3:0] op2;
  } instr_t;

  // Divide-by-zero never reaches the ALU; the controller substitutes a fixed result.
  function automatic logic is_divz(input instr_t i);
    return (i.opc == OPC_DIV) && (i.op2 == 4'd0);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - instruction FIFO with wrap-around pointers and occupancy count
module issue_fifo
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues ALU instructions, issues one at a time and holds each result until accepted
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int         DEPTH    = 2,
  parameter logic [3:0] DIVZ_RES = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_opc,
  input  logic [3:0] in_op1,
  input  logic [3:0] in_op2,
  output logic       alu_enable,
  output logic [3:0] alu_op1,
  output logic [3:0] alu_op2,
  output logic [1:0] alu_opc,
  input  logic [3:0] alu_res,
  input  logic       alu_carry,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_res,
  output logic       out_carry,
  output logic       out_err
);

  state_t                 state;
  state_t                 next_state;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [INSTR_W-1:0]     head_bits;
  instr_t                 head;
  instr_t                 cur;
  logic                   push;
  logic                   pop;
  logic                   alu_enable_d;
  logic                   out_valid_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign head     = instr_t'(head_bits);
  assign cur      = instr_t'({alu_opc, alu_op1, alu_op2});

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_opc, in_op1, in_op2}),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // pop happens only on a transition into ISSUE, including back-to-back from HOLD
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: next_state = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = ST_ISSUE;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_enable_d = (next_state == ST_ISSUE) && !is_divz(head);
    out_valid_d  = (next_state == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_enable <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opc    <= OPC_ADD;
      out_valid  <= 1'b0;
      out_res    <= '0;
      out_carry  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      alu_enable <= alu_enable_d;
      out_valid  <= out_valid_d;
      if (pop) begin
        alu_opc <= head.opc;
        alu_op1 <= head.op1;
        alu_op2 <= head.op2;
      end
      if (state == ST_ISSUE) begin
        if (is_divz(cur)) begin
          out_res   <= DIVZ_RES;
          out_carry <= 1'b0;
          out_err   <= 1'b1;
        end else begin
          out_res   <= alu_res;
          out_carry <= alu_carry;
          out_err   <= 1'b0;
        end
      end
    end
  end

endmodule
